// File: rtl/keyload_seq.sv
// keyload_seq: fetches an unlock key bit-serially from a key store, checks it
// against a trailing even-parity bit and only then drives it onto the key
// lines of the locked netlist. A failed check triggers a new fetch. After
// MAX_RETRY consecutive failures the block locks out until rst.
//
// Ports:
//   clk       in   clock, all state on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   begin a key load (honoured in IDLE/ARMED only)
//   zeroize   in   clear key and return to IDLE (ignored in LOCK)
//   kmem_req  out  requesting next key bit (FETCH)
//   kmem_ack  in   kmem_bit valid; taken only while kmem_req=1
//   kmem_bit  in   serial key bits LSB first, then parity bit
//   key_out   out  key lines D_0..D_(KEY_W-1)
//   key_valid out  key_out holds a verified key
//   busy      out  FETCH or CHECK
//   err       out  one-cycle pulse per parity failure
//   lockout   out  sticky lockout until rst
module keyload_seq #(
  parameter int KEY_W     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             zeroize,
  output logic             kmem_req,
  input  logic             kmem_ack,
  input  logic             kmem_bit,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic             lockout
);

  localparam int IDX_W = $clog2(KEY_W + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_ARMED = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             par_q, par_d;
  logic             kv_q, kv_d;
  logic             pass;

  assign pass      = (par_q == ^shadow_q);
  assign retry_inc = retry_q + RTY_W'(1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    shadow_d = shadow_q;
    key_d    = key_q;
    kv_d     = kv_q;
    par_d    = par_q;

    if (zeroize && (state_q != S_LOCK)) begin
      // zeroize outranks start and any bit accepted in the same cycle
      state_d  = S_IDLE;
      idx_d    = '0;
      retry_d  = '0;
      shadow_d = '0;
      key_d    = '0;
      kv_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ARMED: begin
          // ARMED keeps presenting the old key until a new one verifies
          if (start) begin
            state_d = S_FETCH;
            idx_d   = '0;
            retry_d = '0;
          end
        end
        S_FETCH: begin
          if (kmem_ack) begin
            if (idx_q == IDX_W'(KEY_W)) begin
              par_d   = kmem_bit;
              state_d = S_CHECK;
            end else begin
              for (int unsigned i = 0; i < KEY_W; i++) begin
                if (idx_q == IDX_W'(i)) shadow_d[i] = kmem_bit;
              end
            end
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_CHECK: begin
          if (pass) begin
            key_d   = shadow_q;
            kv_d    = 1'b1;
            retry_d = '0;
            state_d = S_ARMED;
          end else begin
            retry_d = retry_inc;
            if (retry_inc < RTY_W'(MAX_RETRY)) begin
              state_d = S_FETCH;
              idx_d   = '0;
            end else begin
              state_d = S_LOCK;
              key_d   = '0;
              kv_d    = 1'b0;
            end
          end
        end
        S_LOCK: begin
          // only rst leaves LOCK
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      retry_q  <= '0;
      shadow_q <= '0;
      key_q    <= '0;
      kv_q     <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
      kv_q     <= kv_d;
      par_q    <= par_d;
    end
  end

  // All outputs decode registered state only; no input-to-output paths.
  assign kmem_req  = (state_q == S_FETCH);
  assign busy      = (state_q == S_FETCH) || (state_q == S_CHECK);
  assign err       = (state_q == S_CHECK) && !pass;
  assign lockout   = (state_q == S_LOCK);
  assign key_out   = key_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_keyload_seq.sv
module tb_keyload_seq;

  localparam int KEY_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             zeroize;
  logic             kmem_req;
  logic             kmem_ack;
  logic             kmem_bit;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             err;
  logic             lockout;

  keyload_seq #(
    .KEY_W    (KEY_W),
    .MAX_RETRY(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .zeroize  (zeroize),
    .kmem_req (kmem_req),
    .kmem_ack (kmem_ack),
    .kmem_bit (kmem_bit),
    .key_out  (key_out),
    .key_valid(key_valid),
    .busy     (busy),
    .err      (err),
    .lockout  (lockout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected output events: {key_out, key_valid, lockout, err}
  logic [6:0] exp_q[$];
  logic [5:0] prev = '0;
  logic [6:0] mon_got;
  logic [6:0] mon_exp;

  function automatic logic [6:0] ev(input logic [3:0] k, input logic kv,
                                    input logic lk, input logic e);
    return {k, kv, lk, e};
  endfunction

  // Monitor: an event is any change of key_out/key_valid/lockout, or an err pulse.
  always @(negedge clk) begin
    if (rst) begin
      prev = {key_out, key_valid, lockout};
    end else if (({key_out, key_valid, lockout} !== prev) || (err === 1'b1)) begin
      prev    = {key_out, key_valid, lockout};
      mon_got = {key_out, key_valid, lockout, err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_event: unexpected event key=%b valid=%b lockout=%b err=%b, required none",
                 mon_got[6:3], mon_got[2], mon_got[1], mon_got[0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL sb_event: got key=%b valid=%b lockout=%b err=%b, required key=%b valid=%b lockout=%b err=%b",
                   mon_got[6:3], mon_got[2], mon_got[1], mon_got[0],
                   mon_exp[6:3], mon_exp[2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // bits[3:0] = key bits (bit 0 sent first), bits[4] = parity bit.
  // During stall cycles kmem_bit carries the wrong value to catch early capture.
  task automatic load(input logic [4:0] bits, input int gap);
    for (int i = 0; i < KEY_W + 1; i++) begin
      repeat (gap) begin
        kmem_ack = 1'b0;
        kmem_bit = ~bits[i];
        tick();
      end
      kmem_ack = 1'b1;
      kmem_bit = bits[i];
      tick();
    end
    kmem_ack = 1'b0;
    kmem_bit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    zeroize  = 1'b0;
    kmem_ack = 1'b1;
    kmem_bit = 1'b1;

    // Reset with ack held high
    tick();
    tick();
    chk("rst_key_out",   key_out,   0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_kmem_req",  kmem_req,  0);
    chk("rst_lockout",   lockout,   0);
    chk("rst_busy",      busy,      0);
    rst = 1'b0;
    tick();
    chk("idle_ack_ignored_req",  kmem_req, 0);
    chk("idle_ack_ignored_busy", busy,     0);
    kmem_ack = 1'b0;
    tick();

    // Good load: 0,1,0,1 parity 0 -> 4'b1010 seven cycles after start
    exp_q.push_back(ev(4'b1010, 1'b1, 1'b0, 1'b0));
    do_start();
    chk("good_req_after_start", kmem_req, 1);
    load(5'b01010, 0);
    chk("good_check_busy",  busy,      1);
    chk("good_check_valid", key_valid, 0);
    chk("good_check_key",   key_out,   0);
    tick();
    chk("good_valid_t7", key_valid, 1);
    chk("good_key_t7",   key_out,   4'b1010);
    chk("good_busy_low", busy,      0);

    // Zeroize with start in the same cycle from ARMED
    exp_q.push_back(ev(4'b0000, 1'b0, 1'b0, 1'b0));
    zeroize = 1'b1;
    start   = 1'b1;
    tick();
    zeroize = 1'b0;
    start   = 1'b0;
    chk("zs_key",   key_out,   0);
    chk("zs_valid", key_valid, 0);
    chk("zs_req",   kmem_req,  0);
    tick();
    chk("zs_req_stays_low", kmem_req, 0);

    // Stalled load: 3 idle cycles before every bit
    exp_q.push_back(ev(4'b1010, 1'b1, 1'b0, 1'b0));
    do_start();
    load(5'b01010, 3);
    chk("stall_check_key",   key_out,   0);
    chk("stall_check_valid", key_valid, 0);
    tick();
    chk("stall_key",   key_out,   4'b1010);
    chk("stall_valid", key_valid, 1);

    // Zeroize mid-FETCH after 2 bits (beats a same-cycle accepted bit), then reload
    exp_q.push_back(ev(4'b0000, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'b0011, 1'b1, 1'b0, 1'b0));
    do_start();
    kmem_ack = 1'b1;
    kmem_bit = 1'b1;
    tick();
    tick();
    zeroize  = 1'b1;
    kmem_bit = 1'b0;
    tick();
    zeroize  = 1'b0;
    kmem_ack = 1'b0;
    chk("zf_req",  kmem_req, 0);
    chk("zf_busy", busy,     0);
    chk("zf_key",  key_out,  0);
    do_start();
    load(5'b00011, 0);
    tick();
    chk("zf_reload_key", key_out, 4'b0011);

    // Retry then pass, starting from IDLE
    exp_q.push_back(ev(4'b0000, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ev(4'b0000, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(ev(4'b0011, 1'b1, 1'b0, 1'b0));
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    do_start();
    load(5'b10011, 0);
    chk("retry_err", err, 1);
    tick();
    chk("retry_req_next", kmem_req, 1);
    chk("retry_err_pulse", err, 0);
    load(5'b00011, 0);
    chk("retry_pass_err", err, 0);
    tick();
    chk("retry_key",     key_out,   4'b0011);
    chk("retry_valid",   key_valid, 1);
    chk("retry_lockout", lockout,   0);

    // Lockout: two bad attempts from ARMED (old key retained until LOCK)
    exp_q.push_back(ev(4'b0011, 1'b1, 1'b0, 1'b1));
    exp_q.push_back(ev(4'b0011, 1'b1, 1'b0, 1'b1));
    exp_q.push_back(ev(4'b0000, 1'b0, 1'b1, 1'b0));
    do_start();
    load(5'b10011, 0);
    chk("lock_err1", err, 1);
    tick();
    chk("lock_req_retry", kmem_req, 1);
    load(5'b10011, 0);
    chk("lock_err2", err, 1);
    chk("lock_key_retained", key_out, 4'b0011);
    tick();
    chk("lock_lockout", lockout,   1);
    chk("lock_key",     key_out,   0);
    chk("lock_valid",   key_valid, 0);
    chk("lock_req",     kmem_req,  0);
    start    = 1'b1;
    kmem_ack = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("lock_start_ignored", kmem_req, 0);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    tick();
    chk("lock_zeroize_ignored", lockout, 1);
    chk("lock_busy", busy, 0);
    rst = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    kmem_ack = 1'b0;
    chk("lock_rst_clears", lockout, 0);
    tick();
    chk("post_rst_req", kmem_req, 0);

    // rst mid-load after a valid key: nothing partial ever shows
    exp_q.push_back(ev(4'b1010, 1'b1, 1'b0, 1'b0));
    do_start();
    load(5'b01010, 0);
    tick();
    do_start();
    kmem_ack = 1'b1;
    kmem_bit = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rstmid_key",   key_out,   0);
    chk("rstmid_valid", key_valid, 0);
    chk("rstmid_req",   kmem_req,  0);
    rst      = 1'b0;
    kmem_ack = 1'b0;
    tick();
    chk("rstmid_busy", busy, 0);

    tick();
    tick();
    chk("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
